register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
- Integer register file for the single-cycle RISC-V datapath: 32 x 32-bit architectural registers x0..x31.
- Write side decodes one write address into a per-register enable, the demultiplexing counterpart of the operand-select muxes.
- Read side returns two source operands (rs1, rs2) combinationally, plus one debug read port.
- Sits between the instruction decoder and the ALU operand muxes; written by the write-back stage.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = reads return stored value only

Ports:
- clk  input  1  single clock; all writes on the rising edge
- reset_n  input  1  asynchronous active-low reset; clears every register
- read_addr1  input  ADDR_WIDTH  rs1 index
- read_addr2  input  ADDR_WIDTH  rs2 index
- read_data1  output  DATA_WIDTH  rs1 operand
- read_data2  output  DATA_WIDTH  rs2 operand
- write_enable  input  1  write-back strobe (RegWrite)
- write_addr  input  ADDR_WIDTH  rd index
- write_data  input  DATA_WIDTH  write-back value
- debug_addr  input  ADDR_WIDTH  bench/debug read index
- debug_data  output  DATA_WIDTH  debug read value; never bypassed

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits.
- Register 0:
  - Index 0 is hardwired to zero.
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0 on every port, including under bypass.
- Reset:
  - reset_n low clears all registers to 0 immediately, without waiting for clk.
  - While reset_n is low: no write occurs on any clk edge, bypass is suppressed, and all read outputs are 0.
  - Deassertion takes effect on the first clk rising edge at which reset_n is high.
  - Reset asserted mid-operation loses all prior contents; there is no partial retention.
- Write decode:
  - Decode write_addr into one-hot enables qualified by write_enable and write_addr != 0.
  - At the rising edge, exactly the selected register loads write_data; all others hold.
  - write_enable low: no register changes.
- Read:
  - Purely combinational from the address inputs; zero-cycle latency.
  - read_data1 and read_data2 are independent; the same address on both ports returns identical data.
- Bypass:
  - Applies when BYPASS=1, reset_n high, write_enable high, write_addr != 0, and read_addrN == write_addr.
  - read_dataN then equals write_data in the same cycle, before the edge.
  - Otherwise read_dataN returns the stored value.
  - With BYPASS=0 the new value is visible only after the edge.
- Simultaneous events:
  - Both read ports may be bypassed at once.
  - A write and reads of different addresses in the same cycle are unaffected by each other.
  - One write per cycle; there are no write-port conflicts.
- Width rules: no sign or zero extension inside the block; data is stored and returned verbatim.
- Storage must be registers or flops; vendor RAM with synchronous read is not allowed, because read must be asynchronous.

Test Plan:
- Reset: drive reset_n=0 mid-cycle after loading x5=0xDEADBEEF -> debug_data for x5 = 0 immediately. With reset_n low, write_enable=1, write_addr=5, write_data=0x1234 at an edge -> x5 stays 0.
- Basic write/read: write x1=0x00000011 and x31=0xFFFFFFFF on consecutive edges -> read_addr1=1, read_addr2=31 give 0x00000011 and 0xFFFFFFFF. All other registers read 0.
- x0 protection: write_enable=1, write_addr=0, write_data=0xA5A5A5A5 -> read_data1 (addr 0) = 0 before and after the edge, including with BYPASS=1.
- Bypass: BYPASS=1, x7 holds 0x100. Drive write_addr=7, write_data=0x200, write_enable=1, read_addr1=read_addr2=7 -> both read 0x200 before the edge and 0x200 after. debug_data for x7 = 0x100 before the edge, 0x200 after.
- No bypass: same stimulus with BYPASS=0 -> read_data1 = 0x100 before the edge, 0x200 after.
- write_enable low: write_addr=9, write_data=0x55, write_enable=0 for 3 edges -> x9 unchanged (0). Random sweep of 1000 writes/reads against a reference array -> zero mismatches.

Source files
------------

// File: rtl/register_file_2r1w.sv
// rtl/register_file_2r1w.sv - 2-read 1-write integer register file with optional write bypass
// x0 reads as zero everywhere; reads are asynchronous so storage is flops, not RAM.

module register_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      wr_sel;
  logic                  wr_valid;
  logic                  bypass_en;

  assign wr_valid  = write_enable && (write_addr != '0);
  assign bypass_en = (BYPASS != 0) && reset_n && wr_valid;

  // One-hot write decode; bit 0 never asserts, so x0 keeps its reset value of zero.
  always_comb begin
    wr_sel = '0;
    if (wr_valid) begin
      wr_sel[write_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  always_comb begin
    read_data1 = regs[read_addr1];
    if (bypass_en && (read_addr1 == write_addr)) begin
      read_data1 = write_data;
    end
    if (!reset_n || (read_addr1 == '0)) begin
      read_data1 = '0;
    end
  end

  always_comb begin
    read_data2 = regs[read_addr2];
    if (bypass_en && (read_addr2 == write_addr)) begin
      read_data2 = write_data;
    end
    if (!reset_n || (read_addr2 == '0)) begin
      read_data2 = '0;
    end
  end

  // Debug port shows only committed state, never the in-flight write.
  always_comb begin
    debug_data = regs[debug_addr];
    if (!reset_n || (debug_addr == '0)) begin
      debug_data = '0;
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// tb/tb_register_file_2r1w.sv - self-checking bench for register_file_2r1w
// Drives a bypassing and a non-bypassing instance with shared stimulus.

module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  read_addr1, read_addr2, write_addr, debug_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] rd1, rd2, dbg;
  logic [31:0] rd1_nb, rd2_nb, dbg_nb;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  da;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] enb1;
    logic [31:0] edbg_pre;
    logic [31:0] edbg_post;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  register_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1), .read_data2(rd2),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .debug_addr(debug_addr), .debug_data(dbg)
  );

  register_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1_nb), .read_data2(rd2_nb),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .debug_addr(debug_addr), .debug_data(dbg_nb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!reset_n || a == 5'd0) return 32'h0;
    if (byp && write_enable && write_addr != 5'd0 && write_addr == a) return write_data;
    return mem[a];
  endfunction

  task automatic model_edge();
    if (reset_n && write_enable && write_addr != 5'd0) mem[write_addr] = write_data;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  initial begin
    //                we    wa     wd             ra1    ra2    da     e1             e2             enb1           dbg_pre        dbg_post
    vecs[0] = '{1'b1, 5'd1,  32'h00000011, 5'd1,  5'd31, 5'd1,  32'h00000011, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000011};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd1,  5'd31, 5'd31, 32'h00000011, 32'hFFFFFFFF, 32'h00000011, 32'h00000000, 32'hFFFFFFFF};
    vecs[2] = '{1'b0, 5'd0,  32'h00000000, 5'd1,  5'd31, 5'd2,  32'h00000011, 32'hFFFFFFFF, 32'h00000011, 32'h00000000, 32'h00000000};
    vecs[3] = '{1'b1, 5'd0,  32'hA5A5A5A5, 5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[4] = '{1'b1, 5'd7,  32'h00000100, 5'd2,  5'd3,  5'd7,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000100};
    vecs[5] = '{1'b1, 5'd7,  32'h00000200, 5'd7,  5'd7,  5'd7,  32'h00000200, 32'h00000200, 32'h00000100, 32'h00000100, 32'h00000200};
    vecs[6] = '{1'b0, 5'd9,  32'h00000055, 5'd9,  5'd9,  5'd9,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[7] = '{1'b0, 5'd9,  32'h00000055, 5'd9,  5'd9,  5'd9,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[8] = '{1'b0, 5'd9,  32'h00000055, 5'd9,  5'd9,  5'd9,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[9] = '{1'b1, 5'd3,  32'h00000033, 5'd1,  5'd4,  5'd3,  32'h00000011, 32'h00000000, 32'h00000011, 32'h00000000, 32'h00000033};

    reset_n = 1'b0;
    write_enable = 1'b0; write_addr = 5'd0; write_data = 32'h0;
    read_addr1 = 5'd1; read_addr2 = 5'd31; debug_addr = 5'd5;
    model_clear();
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_dbg", dbg, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Table of directed vectors
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      write_enable = vecs[k].we; write_addr = vecs[k].wa; write_data = vecs[k].wd;
      read_addr1 = vecs[k].ra1; read_addr2 = vecs[k].ra2; debug_addr = vecs[k].da;
      #1;
      check($sformatf("vec%0d_rd1_pre", k), rd1, vecs[k].e1);
      check($sformatf("vec%0d_rd2_pre", k), rd2, vecs[k].e2);
      check($sformatf("vec%0d_nb_rd1_pre", k), rd1_nb, vecs[k].enb1);
      check($sformatf("vec%0d_dbg_pre", k), dbg, vecs[k].edbg_pre);
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("vec%0d_dbg_post", k), dbg, vecs[k].edbg_post);
      check($sformatf("vec%0d_nb_rd1_post", k), rd1_nb, mem[vecs[k].ra1]);
      check($sformatf("vec%0d_rd1_post", k), rd1, exp_rd(vecs[k].ra1, 1'b1));
    end

    // Asynchronous reset mid-cycle after loading x5
    @(negedge clk);
    write_enable = 1'b1; write_addr = 5'd5; write_data = 32'hDEADBEEF;
    read_addr1 = 5'd5; read_addr2 = 5'd1; debug_addr = 5'd5;
    @(posedge clk);
    model_edge();
    #1;
    check("rst_seq_loaded", dbg, 32'hDEADBEEF);
    write_enable = 1'b0;
    #1;
    reset_n = 1'b0;
    model_clear();
    #1;
    check("rst_async_dbg", dbg, 32'h0);
    check("rst_async_rd1", rd1, 32'h0);
    check("rst_async_rd2", rd2, 32'h0);
    write_enable = 1'b1; write_addr = 5'd5; write_data = 32'h00001234;
    #1;
    check("rst_bypass_suppressed", rd1, 32'h0);
    check("rst_nb_rd1", rd1_nb, 32'h0);
    @(posedge clk);
    #1;
    check("rst_no_write", dbg, 32'h0);
    @(negedge clk);
    write_enable = 1'b0;
    reset_n = 1'b1;
    #1;
    check("rst_release_dbg", dbg, 32'h0);
    check("rst_release_nb_dbg", dbg_nb, 32'h0);

    // Randomized sweep against the array model
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      write_enable = $urandom_range(0, 3) != 0;
      write_addr = 5'($urandom);
      write_data = $urandom;
      read_addr1 = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom);
      read_addr2 = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom);
      debug_addr = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom);
      #1;
      check("rand_rd1", rd1, exp_rd(read_addr1, 1'b1));
      check("rand_rd2", rd2, exp_rd(read_addr2, 1'b1));
      check("rand_nb_rd1", rd1_nb, exp_rd(read_addr1, 1'b0));
      check("rand_nb_rd2", rd2_nb, exp_rd(read_addr2, 1'b0));
      check("rand_dbg", dbg, exp_rd(debug_addr, 1'b0));
      @(posedge clk);
      model_edge();
    end

    // Full readback of final contents through the debug port
    @(negedge clk);
    write_enable = 1'b0;
    for (int a = 0; a < 32; a++) begin
      debug_addr = 5'(a);
      #1;
      check($sformatf("final_dbg_x%0d", a), dbg, mem[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
